// File: rtl/riu_pkg.sv
// Shared types and constants for the instruction fetch path.
`timescale 1ns/1ps
package riu_pkg;

  localparam int XLEN = 32;

  typedef logic [XLEN-1:0] word_t;

  // One fetched instruction together with the PC it was read from.
  typedef struct packed {
    word_t pc;
    word_t instr;
  } fetch_pkt_t;

  localparam int    INSTR_BYTES = 4;
  localparam word_t NOP_INSTR   = 32'h0000_0013;

endpackage

// File: rtl/fetch_fifo.sv
// Small first-word-fall-through FIFO of fetch packets. Flush wins over push/pop.
`timescale 1ns/1ps
module fetch_fifo
  import riu_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  fetch_pkt_t             din,
  input  logic                   pop,
  input  logic                   flush,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output fetch_pkt_t             head
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_pkt_t    mem_reg [DEPTH];
  logic [AW-1:0] rd_ptr_reg;
  logic [AW-1:0] wr_ptr_reg;
  logic [CW-1:0] count_reg;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == CW'(DEPTH));
  assign count   = count_reg;
  assign head    = mem_reg[rd_ptr_reg];
  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;

  // Write the pushed packet into the slot named by the write pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_reg[i] <= '0;
    end else if (do_push && !flush) begin
      mem_reg[wr_ptr_reg] <= din;
    end
  end

  // Pointer and occupancy bookkeeping; flush empties the FIFO outright.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg <= count_reg + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, credit-limited memory requests, output buffer, redirect.
`timescale 1ns/1ps
module fetch_unit
  import riu_pkg::*;
#(
  parameter word_t RESET_PC   = 32'h0000_0000,
  parameter int    FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc
);

  localparam int    CW         = $clog2(FIFO_DEPTH) + 1;
  localparam word_t ALIGN_MASK = ~word_t'(INSTR_BYTES - 1);

  word_t         pc_reg;
  word_t         pc_next;
  logic [CW-1:0] drop_cnt_reg;
  logic [CW-1:0] drop_cnt_next;
  logic [CW-1:0] fifo_count;
  logic [CW-1:0] inflight;
  fetch_pkt_t    last_reg;
  fetch_pkt_t    out_head;
  fetch_pkt_t    out_din;
  fetch_pkt_t    pcq_head;
  fetch_pkt_t    pcq_din;
  logic          out_full;
  logic          out_empty;
  logic          pcq_full;
  logic          pcq_empty;
  logic          credit;
  logic          req_fire;
  logic          rsp_drop;
  logic          rsp_keep;
  logic          out_pop;

  // Buffered plus outstanding words may never exceed the output buffer size,
  // so every response that is kept is guaranteed a slot.
  assign credit = ({1'b0, fifo_count} + {1'b0, inflight}) < (CW + 1)'(FIFO_DEPTH);

  assign imem_req_valid = rst_n && !redirect_valid && credit && !pcq_full && !out_full;
  assign imem_req_addr  = pc_reg;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // A response is stale if it belongs to fetches issued before a redirect.
  assign rsp_drop = imem_rsp_valid && (redirect_valid || (drop_cnt_reg != '0));
  assign rsp_keep = imem_rsp_valid && !rsp_drop && !pcq_empty;

  assign instr_valid = !out_empty && !redirect_valid;
  assign out_pop     = instr_valid && instr_ready;
  assign instr       = out_empty ? last_reg.instr : out_head.instr;
  assign instr_pc    = out_empty ? last_reg.pc    : out_head.pc;

  // The PC queue's instr field is tied to zero, so OR-ing it in changes nothing.
  assign pcq_din = '{pc: pc_reg, instr: '0};
  assign out_din = '{pc: pcq_head.pc, instr: imem_rsp_data | pcq_head.instr};

  // PCs of outstanding requests; its occupancy is the in-flight count.
  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_pc_queue (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (req_fire),
    .din   (pcq_din),
    .pop   (imem_rsp_valid),
    .flush (1'b0),
    .full  (pcq_full),
    .empty (pcq_empty),
    .count (inflight),
    .head  (pcq_head)
  );

  // Instruction words waiting for decode.
  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_out_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (rsp_keep),
    .din   (out_din),
    .pop   (out_pop),
    .flush (redirect_valid),
    .full  (out_full),
    .empty (out_empty),
    .count (fifo_count),
    .head  (out_head)
  );

  // Next PC: redirect target, sequential advance on an accepted request, or hold.
  always_comb begin
    pc_next = pc_reg;
    if (redirect_valid)  pc_next = redirect_pc & ALIGN_MASK;
    else if (req_fire)   pc_next = pc_reg + word_t'(INSTR_BYTES);
  end

  // Stale-response count: a redirect marks every outstanding fetch as stale.
  always_comb begin
    drop_cnt_next = drop_cnt_reg;
    if (redirect_valid)  drop_cnt_next = inflight - CW'(imem_rsp_valid);
    else if (rsp_drop)   drop_cnt_next = drop_cnt_reg - CW'(1);
  end

  // PC, stale count and the last presented packet (held while the buffer is empty).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_reg       <= RESET_PC & ALIGN_MASK;
      drop_cnt_reg <= '0;
      last_reg     <= '0;
    end else begin
      pc_reg       <= pc_next;
      drop_cnt_reg <= drop_cnt_next;
      if (!out_empty) last_reg <= out_head;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit with an in-order, fixed-latency memory model.
`timescale 1ns/1ps
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr;
  logic [31:0] instr_pc;

  fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] pc; logic [31:0] data; } exp_t;
  typedef struct { logic [31:0] data; int due; } mrsp_t;

  exp_t        expq[$];
  mrsp_t       memq[$];
  logic [31:0] popq[$];
  logic [31:0] datq[$];

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   lat = 1;
  logic req_rdy = 1'b1;
  logic dec_rdy = 1'b1;

  logic        obs_req_valid;
  logic [31:0] obs_req_addr;
  logic        obs_ivalid;
  logic [31:0] obs_ipc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] memword(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h0000_0013;
      32'h0000_0004: return 32'h0050_0093;
      32'h0000_0008: return 32'h00a0_0113;
      default:       return {a[15:0], a[31:16]} ^ 32'h5A5A_0F0F;
    endcase
  endfunction

  // One clock cycle: drive at the falling edge, observe 1ns later, then cross the rising edge.
  task automatic cycle(input bit redir, input logic [31:0] rpc);
    exp_t e;
    redirect_valid = redir;
    redirect_pc    = rpc;
    imem_req_ready = req_rdy;
    instr_ready    = dec_rdy;
    if (memq.size() > 0 && memq[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = memq[0].data;
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'hDEAD_BEEF;
    end
    #1;
    obs_req_valid = imem_req_valid;
    obs_req_addr  = imem_req_addr;
    obs_ivalid    = instr_valid;
    obs_ipc       = instr_pc;
    if (redir) begin
      check("redir_req_valid", 32'(imem_req_valid), 32'd0);
      check("redir_instr_valid", 32'(instr_valid), 32'd0);
    end
    if (imem_req_valid && imem_req_ready) begin
      memq.push_back('{data: memword(imem_req_addr), due: cyc + lat});
      expq.push_back('{pc: imem_req_addr, data: memword(imem_req_addr)});
      $display("req  cyc=%0d addr=%h", cyc, imem_req_addr);
    end
    if (instr_valid && instr_ready) begin
      if (expq.size() == 0) begin
        check("unexpected_pop", 32'(instr_valid), 32'd0);
      end else begin
        e = expq.pop_front();
        check("sb_pc", instr_pc, e.pc);
        check("sb_instr", instr, e.data);
      end
      popq.push_back(instr_pc);
      datq.push_back(instr);
      $display("pop  cyc=%0d pc=%h instr=%h", cyc, instr_pc, instr);
    end
    if (redir) expq.delete();
    if (imem_rsp_valid) memq.delete(0);
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 32'h0);
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_req_ready = 1'b0;
    instr_ready    = 1'b0;
    memq.delete();
    expq.delete();
    popq.delete();
    datq.delete();
    repeat (2) @(negedge clk);
    #1;
    check("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check("rst_instr_valid", 32'(instr_valid), 32'd0);
    check("rst_instr", instr, 32'h0);
    check("rst_instr_pc", instr_pc, 32'h0);
    check("rst_req_addr", imem_req_addr, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    // Streaming from reset, latency 1, decode always ready.
    lat = 1; req_rdy = 1'b1; dec_rdy = 1'b1;
    do_reset();
    cycle(1'b0, 32'h0);
    check("first_req_valid", 32'(obs_req_valid), 32'd1);
    check("first_req_addr", obs_req_addr, 32'h0);
    run(11);
    check("stream_npops", 32'(popq.size() >= 6), 32'd1);
    if (popq.size() >= 3) begin
      check("stream_pc0", popq[0], 32'h0);
      check("stream_pc1", popq[1], 32'h4);
      check("stream_pc2", popq[2], 32'h8);
      check("stream_d0", datq[0], 32'h0000_0013);
      check("stream_d1", datq[1], 32'h0050_0093);
      check("stream_d2", datq[2], 32'h00a0_0113);
    end

    // Decode stalled for 10 cycles: buffer fills, requests stop, head holds.
    do_reset();
    dec_rdy = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, 32'h0);
      if (i >= 3) begin
        check("stall_req_valid", 32'(obs_req_valid), 32'd0);
        check("stall_instr_valid", 32'(obs_ivalid), 32'd1);
        check("stall_head_pc", obs_ipc, 32'h0);
      end
    end
    dec_rdy = 1'b1;
    cycle(1'b0, 32'h0);
    // Memory not ready for 5 cycles: request held at 0x8.
    req_rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 32'h0);
      check("hold_req_valid", 32'(obs_req_valid), 32'd1);
      check("hold_req_addr", obs_req_addr, 32'h8);
    end
    req_rdy = 1'b1;
    run(10);
    check("stall_npops", 32'(popq.size() >= 3), 32'd1);
    if (popq.size() >= 3) begin
      check("stall_pop0", popq[0], 32'h0);
      check("stall_pop1", popq[1], 32'h4);
      check("stall_pop2", popq[2], 32'h8);
    end

    // Latency 3, redirect with two fetches outstanding.
    do_reset();
    lat = 3;
    run(2);
    cycle(1'b1, 32'h0000_0100);
    run(12);
    check("redir_npops", 32'(popq.size() >= 2), 32'd1);
    if (popq.size() >= 2) begin
      check("redir_pop0", popq[0], 32'h0000_0100);
      check("redir_pop1", popq[1], 32'h0000_0104);
    end

    // Misaligned redirect target is aligned down.
    popq.delete();
    cycle(1'b1, 32'h0000_0203);
    cycle(1'b0, 32'h0);
    check("align_req_addr", obs_req_addr, 32'h0000_0200);
    run(12);
    check("align_npops", 32'(popq.size() >= 1), 32'd1);
    if (popq.size() >= 1) check("align_pop0", popq[0], 32'h0000_0200);

    // Redirect to the top of the address space: PC wraps to zero.
    popq.delete();
    cycle(1'b1, 32'hFFFF_FFFC);
    run(14);
    check("wrap_npops", 32'(popq.size() >= 2), 32'd1);
    if (popq.size() >= 2) begin
      check("wrap_pop0", popq[0], 32'hFFFF_FFFC);
      check("wrap_pop1", popq[1], 32'h0000_0000);
    end

    // Reset asserted mid-stream with a full buffer.
    do_reset();
    lat = 1; dec_rdy = 1'b0;
    run(6);
    check("full_instr_valid", 32'(obs_ivalid), 32'd1);
    #3 rst_n = 1'b0;
    #1;
    check("async_instr_valid", 32'(instr_valid), 32'd0);
    check("async_req_valid", 32'(imem_req_valid), 32'd0);
    check("async_instr_pc", instr_pc, 32'h0);
    do_reset();
    dec_rdy = 1'b1;
    cycle(1'b0, 32'h0);
    check("restart_req_addr", obs_req_addr, 32'h0);
    run(8);
    check("restart_npops", 32'(popq.size() >= 2), 32'd1);
    if (popq.size() >= 2) begin
      check("restart_pop0", popq[0], 32'h0);
      check("restart_pop1", popq[1], 32'h4);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
